// File: rtl/axi_spm_pkg.sv
// Shared types for the AXI scratchpad responder: channel structs, FSM states and the
// WRAP-burst mask helper.
package axi_spm_pkg;

    localparam int unsigned AxiAddrW = 64;
    localparam int unsigned AxiDataW = 64;
    localparam int unsigned AxiIdW   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [2:0]          prot;
        logic [5:0]          atop;
    } spm_aw_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiAddrW-1:0] addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [2:0]          prot;
    } spm_ar_chan_t;

    typedef struct packed {
        logic [AxiDataW-1:0]   data;
        logic [AxiDataW/8-1:0] strb;
        logic                  last;
    } spm_w_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0] id;
        logic [1:0]        resp;
    } spm_b_chan_t;

    typedef struct packed {
        logic [AxiIdW-1:0]   id;
        logic [AxiDataW-1:0] data;
        logic [1:0]          resp;
        logic                last;
    } spm_r_chan_t;

    typedef struct packed {
        spm_aw_chan_t aw;
        logic         aw_valid;
        spm_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        spm_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } spm_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        spm_b_chan_t b;
        logic        r_valid;
        spm_r_chan_t r;
    } spm_rsp_t;

    typedef enum logic [1:0] {RIdle, RMem, RWait, RResp} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    // Byte mask covering one wrap window: (len+1) * 2**size bytes.
    function automatic logic [AxiAddrW-1:0] wrap_mask(input logic [7:0] len, input logic [2:0] size);
        logic [AxiAddrW-1:0] beats;
        beats = AxiAddrW'(len) + AxiAddrW'(1);
        return (beats << size) - AxiAddrW'(1);
    endfunction

endpackage

// File: rtl/axi_spm_burst_addr.sv
// Combinational AXI4 next-beat address for FIXED, INCR and WRAP bursts.
module axi_spm_burst_addr
    import axi_spm_pkg::*;
#(
    parameter int unsigned AddrWidth = 64
) (
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [7:0]           len_i,
    input  logic [2:0]           size_i,
    input  logic [1:0]           burst_i,
    output logic [AddrWidth-1:0] next_addr_o
);

    logic [AddrWidth-1:0] step, aligned, incr, mask;

    always_comb begin
        step    = AddrWidth'(1) << size_i;
        aligned = addr_i & ~(step - AddrWidth'(1));
        incr    = aligned + step;
        mask    = AddrWidth'(wrap_mask(len_i, size_i));
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~mask) | (incr & mask);
            default:     next_addr_o = incr;
        endcase
    end

endmodule

// File: rtl/axi_spm_responder.sv
// AXI4 subordinate terminating on a single-port SRAM scratchpad; independent read/write FSMs
// share the SRAM port per beat. Optional address range check: AXI_SPM_RANGE_CHECK_EN.
module axi_spm_responder
    import axi_spm_pkg::*;
#(
    parameter int unsigned                AxiAddrWidth = 64,
    parameter int unsigned                AxiDataWidth = 64,
    parameter int unsigned                AxiIdWidth   = 4,
    parameter type                        axi_req_t    = spm_req_t,
    parameter type                        axi_rsp_t    = spm_rsp_t,
    parameter int unsigned                NumWords     = 1024,
    parameter logic [AxiAddrWidth-1:0]    BaseAddr     = 64'h7000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  axi_req_t                      axi_req_i,
    output axi_rsp_t                      axi_resp_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [$clog2(NumWords)-1:0]   mem_addr_o,
    output logic [AxiDataWidth-1:0]       mem_wdata_o,
    output logic [AxiDataWidth/8-1:0]     mem_be_o,
    input  logic [AxiDataWidth-1:0]       mem_rdata_i
);

    localparam int unsigned IdxW    = $clog2(NumWords);
    localparam int unsigned AddrLsb = $clog2(AxiDataWidth/8);

    r_state_e                r_state_q, r_state_d;
    logic [AxiIdWidth-1:0]   r_id_q, r_id_d;
    logic [AxiAddrWidth-1:0] r_addr_q, r_addr_d, r_next, r_off;
    logic [7:0]              r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]              r_size_q, r_size_d;
    logic [1:0]              r_burst_q, r_burst_d, r_resp_q, r_resp_d;
    logic [AxiDataWidth-1:0] r_data_q, r_data_d;

    w_state_e                w_state_q, w_state_d;
    logic [AxiIdWidth-1:0]   w_id_q, w_id_d;
    logic [AxiAddrWidth-1:0] w_addr_q, w_addr_d, w_next, w_off;
    logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]              w_size_q, w_size_d;
    logic [1:0]              w_burst_q, w_burst_d;
    logic                    w_err_q, w_err_d, w_dec_q, w_dec_d;

    logic rr_q, rr_d;  // 0: read wins the next contended cycle
    logic rd_pend, wr_pend, rd_gnt, wr_gnt, r_oor, w_oor;
    logic ar_ready, aw_ready, w_ready, r_valid, b_valid, r_last, w_last_exp;

    axi_spm_burst_addr #(.AddrWidth(AxiAddrWidth)) u_r_addr (
        .addr_i     (r_addr_q),
        .len_i      (r_len_q),
        .size_i     (r_size_q),
        .burst_i    (r_burst_q),
        .next_addr_o(r_next)
    );

    axi_spm_burst_addr #(.AddrWidth(AxiAddrWidth)) u_w_addr (
        .addr_i     (w_addr_q),
        .len_i      (w_len_q),
        .size_i     (w_size_q),
        .burst_i    (w_burst_q),
        .next_addr_o(w_next)
    );

    assign r_off = r_addr_q - BaseAddr;
    assign w_off = w_addr_q - BaseAddr;

`ifdef AXI_SPM_RANGE_CHECK_EN
    localparam logic [AxiAddrWidth-1:0] SpmBytes = AxiAddrWidth'(NumWords * (AxiDataWidth/8));
    // Offset is unsigned, so addresses below BaseAddr wrap to huge values and fail too.
    assign r_oor = (r_off >= SpmBytes);
    assign w_oor = (w_off >= SpmBytes);
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    assign r_last     = (r_cnt_q == r_len_q);
    assign w_last_exp = (w_cnt_q == w_len_q);

    assign rd_pend = (r_state_q == RMem) && !r_oor;
    assign wr_pend = (w_state_q == WData) && axi_req_i.w_valid && !w_oor;
    assign rd_gnt  = rd_pend && (!wr_pend || !rr_q);
    assign wr_gnt  = wr_pend && (!rd_pend || rr_q);
    assign rr_d    = (rd_pend && wr_pend) ? ~rr_q : rr_q;

    assign mem_req_o   = rd_gnt | wr_gnt;
    assign mem_we_o    = wr_gnt;
    assign mem_addr_o  = wr_gnt ? w_off[AddrLsb +: IdxW] : r_off[AddrLsb +: IdxW];
    assign mem_wdata_o = axi_req_i.w.data;
    assign mem_be_o    = axi_req_i.w.strb;

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        ar_ready  = 1'b0;
        r_valid   = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                ar_ready = 1'b1;
                if (axi_req_i.ar_valid) begin
                    r_id_d    = axi_req_i.ar.id;
                    r_addr_d  = axi_req_i.ar.addr;
                    r_len_d   = axi_req_i.ar.len;
                    r_size_d  = axi_req_i.ar.size;
                    r_burst_d = axi_req_i.ar.burst;
                    r_cnt_d   = '0;
                    r_state_d = RMem;
                end
            end
            RMem: begin
                if (r_oor) begin
                    r_data_d  = '0;
                    r_resp_d  = RESP_DECERR;
                    r_state_d = RResp;
                end else if (rd_gnt) begin
                    r_state_d = RWait;
                end
            end
            RWait: begin
                r_data_d  = mem_rdata_i;
                r_resp_d  = RESP_OKAY;
                r_state_d = RResp;
            end
            RResp: begin
                r_valid = 1'b1;
                if (axi_req_i.r_ready) begin
                    if (r_last) begin
                        r_state_d = RIdle;
                    end else begin
                        r_addr_d  = r_next;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_state_d = RMem;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        w_dec_d   = w_dec_q;
        aw_ready  = 1'b0;
        w_ready   = 1'b0;
        b_valid   = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                aw_ready = 1'b1;
                if (axi_req_i.aw_valid) begin
                    w_id_d    = axi_req_i.aw.id;
                    w_addr_d  = axi_req_i.aw.addr;
                    w_len_d   = axi_req_i.aw.len;
                    w_size_d  = axi_req_i.aw.size;
                    w_burst_d = axi_req_i.aw.burst;
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_dec_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                w_ready = wr_gnt || w_oor;
                if (axi_req_i.w_valid && w_ready) begin
                    // The beat counter ends the burst; a misplaced w.last only flags an error.
                    if (axi_req_i.w.last != w_last_exp) w_err_d = 1'b1;
                    if (w_oor) w_dec_d = 1'b1;
                    if (w_last_exp) begin
                        w_state_d = WResp;
                    end else begin
                        w_addr_d = w_next;
                        w_cnt_d  = w_cnt_q + 8'd1;
                    end
                end
            end
            WResp: begin
                b_valid = 1'b1;
                if (axi_req_i.b_ready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.r_valid  = r_valid;
        axi_resp_o.r.id     = r_id_q;
        axi_resp_o.r.data   = r_data_q;
        axi_resp_o.r.resp   = r_resp_q;
        axi_resp_o.r.last   = r_last;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.b.id     = w_id_q;
        axi_resp_o.b.resp   = w_dec_q ? RESP_DECERR : (w_err_q ? RESP_SLVERR : RESP_OKAY);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_cnt_q   <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            w_dec_q   <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            w_dec_q   <= w_dec_d;
            rr_q      <= rr_d;
        end
    end

    // Lock/prot/atop are deliberately ignored; offset bits outside the index are don't-care.
    logic unused_sig;
    assign unused_sig = ^{axi_req_i.aw.lock, axi_req_i.aw.prot, axi_req_i.aw.atop,
                          axi_req_i.ar.lock, axi_req_i.ar.prot, r_off, w_off};

endmodule
